// File: rtl/busca_comparador_ctrl_pkg.sv
// Shared definitions for the busca search controller: the comparator width,
// the default table depth and the controller state encoding.
package busca_pkg;

  localparam int BUSCA_WIDTH     = 6;
  localparam int BUSCA_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } busca_state_e;

endpackage

// File: rtl/busca_comparador_ctrl_cmp_eq6.sv
// 6-bit equality comparator: XNOR each bit pair, AND-reduce the result.
// Purely combinational; entry validity is handled by the caller.
module cmp_eq6
  import busca_pkg::*;
(
  input  logic [BUSCA_WIDTH-1:0] a_i,
  input  logic [BUSCA_WIDTH-1:0] b_i,
  output logic                   eq_o
);

  logic [BUSCA_WIDTH-1:0] same_bits;

  assign same_bits = a_i ~^ b_i;
  assign eq_o      = &same_bits;

endmodule

// File: rtl/busca_comparador_ctrl.sv
// Sequential search controller. Holds a DEPTH-entry table of 6-bit values
// with per-entry valid bits and, on start, walks the table one entry per
// clock through a single cmp_eq6 instance, reporting found / lowest index /
// match count with a one-cycle done pulse.
// Optional build macro: BUSCA_EARLY_EXIT_EN -- stop the scan at the first
// valid hit (match_count is then 1 on a hit, 0 on a miss).
module busca_comparador_ctrl
  import busca_pkg::*;
#(
  parameter int DEPTH = BUSCA_DEPTH_DEF,
  parameter int WIDTH = BUSCA_WIDTH,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [WIDTH-1:0] key,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IW-1:0]    match_idx,
  output logic [IW:0]      match_count
);

  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);
  localparam logic [IW:0]   CNT_ONE  = (IW + 1)'(1);

  // Table storage (data, never reset) and its valid bits (control, reset).
  logic [WIDTH-1:0] tbl_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // Scan state.
  busca_state_e     state_q, state_d;
  logic [WIDTH-1:0] key_q;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW:0]      cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [IW-1:0]    fidx_q, fidx_d;

  // Registered outputs.
  logic             busy_q, done_q, found_q;
  logic [IW-1:0]    midx_q;
  logic [IW:0]      mcnt_q;

  logic             cmp_eq;
  logic             hit;
  logic             last;
  logic             accept;
  logic             wr_ok;
  logic             finish;

  cmp_eq6 u_cmp (
    .a_i  (tbl_q[idx_q]),
    .b_i  (key_q),
    .eq_o (cmp_eq)
  );

  assign hit    = cmp_eq & valid_q[idx_q];
  assign last   = (idx_q == IDX_LAST);
  assign accept = (state_q == ST_IDLE) & start;
  assign wr_ok  = (state_q == ST_IDLE) & wr_en;
  assign finish = (state_q == ST_SCAN) & (state_d == ST_DONE);

  // Next-state logic: scan bookkeeping and the IDLE/SCAN/DONE sequencing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    fidx_d  = fidx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          cnt_d   = '0;
          first_d = 1'b0;
          fidx_d  = '0;
        end
      end
      ST_SCAN: begin
        if (hit) begin
          cnt_d = cnt_q + CNT_ONE;
          if (!first_q) begin
            first_d = 1'b1;
            fidx_d  = idx_q;
          end
        end
        // idx stops at the last entry instead of wrapping.
        if (!last) begin
          idx_d = idx_q + IDX_ONE;
        end
`ifdef BUSCA_EARLY_EXIT_EN
        if (hit || last) begin
          state_d = ST_DONE;
        end
`else
        if (last) begin
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers: state, scratch results, valid bits and outputs.
  // Results are loaded on the edge entering DONE so they are visible
  // together with the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      fidx_q  <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      midx_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      fidx_q  <= fidx_d;
      if (wr_ok) begin
        valid_q[wr_addr] <= 1'b1;
      end
      busy_q <= (state_d != ST_IDLE);
      done_q <= (state_d == ST_DONE);
      if (finish) begin
        found_q <= first_d;
        midx_q  <= fidx_d;
        mcnt_q  <= cnt_d;
      end
    end
  end

  // Data registers: table contents and the latched key. Writes are only
  // taken in IDLE, so the table is frozen while a scan is running.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      tbl_q[wr_addr] <= wr_data;
    end
    if (accept) begin
      key_q <= key;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign match_idx   = midx_q;
  assign match_count = mcnt_q;

endmodule

// File: tb/tb_busca_comparador_ctrl.sv
// Directed testbench for busca_comparador_ctrl (DEPTH = 8).
module tb_busca_comparador_ctrl;

  localparam int DEPTH = 8;
  localparam int IW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [5:0]    wr_data = '0;
  logic          start = 1'b0;
  logic [5:0]    key = '0;
  logic          busy;
  logic          done;
  logic          found;
  logic [IW-1:0] match_idx;
  logic [IW:0]   match_count;

  int tests_run    = 0;
  int tests_failed = 0;

  busca_comparador_ctrl #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .key         (key),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .match_idx   (match_idx),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [IW-1:0] a, input logic [5:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Start a search, return edges from accept to done, then return to IDLE.
  task automatic run_search(input logic [5:0] k, output int lat, output bit got,
                            output logic busy_seen);
    start = 1'b1;
    key   = k;
    step();
    start     = 1'b0;
    wr_en     = 1'b0;
    busy_seen = busy;
    lat = 0;
    got = 1'b0;
    for (int n = 1; n <= DEPTH + 4; n++) begin
      step();
      if (done) begin
        lat = n;
        got = 1'b1;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %0b want 0", done); end
    tests_run++; if (found !== 1'b0) begin tests_failed++; $display("FAIL reset_found got %0b want 0", found); end
    tests_run++; if (match_idx !== 3'd0) begin tests_failed++; $display("FAIL reset_idx got %0d want 0", match_idx); end
    tests_run++; if (match_count !== 4'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", match_count); end
  endtask

  task automatic test_empty_search();
    int lat; bit got; logic bz;
    run_search(6'b000000, lat, got, bz);
    tests_run++; if (bz !== 1'b1) begin tests_failed++; $display("FAIL empty_busy got %0b want 1", bz); end
    tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL empty_done_seen got %0b want 1", got); end
    tests_run++; if (lat != DEPTH) begin tests_failed++; $display("FAIL empty_latency got %0d want %0d", lat, DEPTH); end
    tests_run++; if (found !== 1'b0) begin tests_failed++; $display("FAIL empty_found got %0b want 0", found); end
    tests_run++; if (match_count !== 4'd0) begin tests_failed++; $display("FAIL empty_count got %0d want 0", match_count); end
    tests_run++; if (match_idx !== 3'd0) begin tests_failed++; $display("FAIL empty_idx got %0d want 0", match_idx); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL empty_done_pulse got %0b want 0", done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL empty_busy_end got %0b want 0", busy); end
  endtask

  task automatic test_two_hits();
    int lat; bit got; logic bz;
    int exp_lat; int exp_cnt;
`ifdef BUSCA_EARLY_EXIT_EN
    exp_lat = 3; exp_cnt = 1;
`else
    exp_lat = DEPTH; exp_cnt = 2;
`endif
    do_write(3'd2, 6'b101010);
    do_write(3'd5, 6'b101010);
    run_search(6'b101010, lat, got, bz);
    tests_run++; if (got !== 1'b1 || lat != exp_lat) begin tests_failed++; $display("FAIL two_hits_latency got %0d (done %0b) want %0d", lat, got, exp_lat); end
    tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL two_hits_found got %0b want 1", found); end
    tests_run++; if (match_idx !== 3'd2) begin tests_failed++; $display("FAIL two_hits_idx got %0d want 2", match_idx); end
    tests_run++; if (match_count != exp_cnt) begin tests_failed++; $display("FAIL two_hits_count got %0d want %0d", match_count, exp_cnt); end
  endtask

  task automatic test_near_miss();
    int lat; bit got; logic bz;
    do_write(3'd7, 6'b100111);
    run_search(6'b100110, lat, got, bz);
    tests_run++; if (got !== 1'b1 || lat != DEPTH) begin tests_failed++; $display("FAIL near_miss_latency got %0d (done %0b) want %0d", lat, got, DEPTH); end
    tests_run++; if (found !== 1'b0) begin tests_failed++; $display("FAIL near_miss_found got %0b want 0", found); end
    tests_run++; if (match_count !== 4'd0) begin tests_failed++; $display("FAIL near_miss_count got %0d want 0", match_count); end
    tests_run++; if (match_idx !== 3'd0) begin tests_failed++; $display("FAIL near_miss_idx got %0d want 0", match_idx); end
    run_search(6'b100111, lat, got, bz);
    tests_run++; if (got !== 1'b1 || lat != DEPTH) begin tests_failed++; $display("FAIL last_hit_latency got %0d (done %0b) want %0d", lat, got, DEPTH); end
    tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL last_hit_found got %0b want 1", found); end
    tests_run++; if (match_idx !== 3'd7) begin tests_failed++; $display("FAIL last_hit_idx got %0d want 7", match_idx); end
    tests_run++; if (match_count !== 4'd1) begin tests_failed++; $display("FAIL last_hit_count got %0d want 1", match_count); end
  endtask

  task automatic test_write_with_start();
    int lat; bit got; logic bz;
    int exp_lat;
`ifdef BUSCA_EARLY_EXIT_EN
    exp_lat = 1;
`else
    exp_lat = DEPTH;
`endif
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = 6'b111111;
    run_search(6'b111111, lat, got, bz);
    tests_run++; if (got !== 1'b1 || lat != exp_lat) begin tests_failed++; $display("FAIL same_cycle_latency got %0d (done %0b) want %0d", lat, got, exp_lat); end
    tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL same_cycle_found got %0b want 1", found); end
    tests_run++; if (match_idx !== 3'd0) begin tests_failed++; $display("FAIL same_cycle_idx got %0d want 0", match_idx); end
    tests_run++; if (match_count !== 4'd1) begin tests_failed++; $display("FAIL same_cycle_count got %0d want 1", match_count); end
  endtask

  task automatic test_busy_ignore();
    int lat; bit got; logic bz;
    int pulses; int exp_cnt;
`ifdef BUSCA_EARLY_EXIT_EN
    exp_cnt = 1;
`else
    exp_cnt = 2;
`endif
    start = 1'b1;
    key   = 6'b101010;
    step();
    start = 1'b0;
    step();
    start   = 1'b1;
    key     = 6'b000001;
    wr_en   = 1'b1;
    wr_addr = 3'd3;
    wr_data = 6'b000001;
    step();
    start = 1'b0;
    wr_en = 1'b0;
    pulses = 0;
    for (int n = 0; n < 3 * DEPTH; n++) begin
      if (done) pulses++;
      step();
    end
    tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL busy_ignore_pulses got %0d want 1", pulses); end
    tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL busy_ignore_found got %0b want 1", found); end
    tests_run++; if (match_count != exp_cnt) begin tests_failed++; $display("FAIL busy_ignore_count got %0d want %0d", match_count, exp_cnt); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL busy_ignore_idle got %0b want 0", busy); end
    run_search(6'b000001, lat, got, bz);
    tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL entry3_done got %0b want 1", got); end
    tests_run++; if (found !== 1'b0) begin tests_failed++; $display("FAIL entry3_unchanged found got %0b want 0", found); end
  endtask

  task automatic test_back_to_back();
    int first_at; int second_at; int exp_gap;
`ifdef BUSCA_EARLY_EXIT_EN
    exp_gap = 4;
`else
    exp_gap = DEPTH + 2;
`endif
    do_write(3'd1, 6'b001100);
    first_at  = -1;
    second_at = -1;
    start = 1'b1;
    key   = 6'b001100;
    for (int n = 1; n <= 4 * (DEPTH + 2); n++) begin
      step();
      if (done) begin
        if (first_at < 0) first_at = n;
        else begin
          second_at = n;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    step();
    tests_run++; if (first_at < 0 || second_at < 0 || (second_at - first_at) != exp_gap) begin tests_failed++; $display("FAIL back_to_back_gap got %0d want %0d", second_at - first_at, exp_gap); end
    tests_run++; if (match_idx !== 3'd1) begin tests_failed++; $display("FAIL back_to_back_idx got %0d want 1", match_idx); end
  endtask

  task automatic test_reset_mid_scan();
    int lat; bit got; logic bz; int pulses;
    run_search(6'b101010, lat, got, bz);
    tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_found got %0b want 1", found); end
    start = 1'b1;
    key   = 6'b101010;
    step();
    start = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy got %0b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL midreset_done got %0b want 0", done); end
    tests_run++; if (found !== 1'b0) begin tests_failed++; $display("FAIL midreset_found got %0b want 0", found); end
    tests_run++; if (match_idx !== 3'd0) begin tests_failed++; $display("FAIL midreset_idx got %0d want 0", match_idx); end
    tests_run++; if (match_count !== 4'd0) begin tests_failed++; $display("FAIL midreset_count got %0d want 0", match_count); end
    pulses = 0;
    for (int n = 0; n < DEPTH + 4; n++) begin
      if (done) pulses++;
      step();
    end
    tests_run++; if (pulses != 0) begin tests_failed++; $display("FAIL midreset_no_done got %0d pulses want 0", pulses); end
    run_search(6'b101010, lat, got, bz);
    tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL post_reset_done got %0b want 1", got); end
    tests_run++; if (found !== 1'b0) begin tests_failed++; $display("FAIL post_reset_found got %0b want 0", found); end
    tests_run++; if (match_count !== 4'd0) begin tests_failed++; $display("FAIL post_reset_count got %0d want 0", match_count); end
  endtask

  initial begin
    #1;
    test_reset();
    test_empty_search();
    test_two_hits();
    test_near_miss();
    test_write_with_start();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
